// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants for the reset vector and next-PC source codes.
package fetch_stage_pkg;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;
endpackage

// File: rtl/fetch_stage_npc.sv
// npc: combinational next-PC select; redirect targets are relative to the instruction in ID.
module npc
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic        br_taken,
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] next_pc
);
  logic [31:0] seq, link, br;
  assign seq  = pc + 32'd4;
  assign link = id_pc + 32'd4;
  assign br   = link + {{14{imm16[15]}}, imm16, 2'b00};
  assign next_pc = sel == NPC_JR ? rs_val :
                   sel == NPC_J ? {link[31:28], imm26, 2'b00} :
                   (sel == NPC_BR && br_taken) ? br : seq;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register with stall, flush and delay-slot redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_imm26,
  input  logic [31:0] id_rs_val,
  output logic [31:0] i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid
);
  logic [31:0] pc, next_pc;
  npc u_npc (
    .sel     (npc_sel),
    .br_taken(br_taken),
    .pc      (pc),
    .id_pc   (id_pc),
    .imm16   (id_imm16),
    .imm26   (id_imm26),
    .rs_val  (id_rs_val),
    .next_pc (next_pc)
  );
  assign i_addr = pc;
  // A stalled redirect is dropped here; the held ID instruction re-requests it after the stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_RESET;
      id_instr <= '0;
      id_pc    <= '0;
      id_pc8   <= '0;
      id_valid <= 1'b0;
    end else begin
      if (!stall) pc <= next_pc;
      if (flush || !stall) begin
        id_instr <= flush ? 32'd0 : i_rdata;
        id_valid <= !flush;
        id_pc    <= pc;
        id_pc8   <= pc + 32'd8;
      end
    end
  end
endmodule
